// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch path: sequencer states, next-PC
// select codes and architectural constants.
package mips_pkg;

    localparam int unsigned WORD_BYTES        = 4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

    // Sequencer states, kept as plain constants for legacy compatibility
    typedef logic [1:0] seq_state_t;
    localparam seq_state_t BOOT = 2'd0;
    localparam seq_state_t RUN  = 2'd1;
    localparam seq_state_t HALT = 2'd2;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_J,
        SEL_JR
    } pc_sel_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC target computation and priority select (JR > J > branch > sequential).
// Purely combinational. target_wrap flags a sequential or branch target whose
// true value falls outside the 32-bit address space.
module next_pc_mux
    import mips_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_index,
    input  logic        jump_reg,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] target,
    output logic        target_wrap
);

    // Two guard bits catch both carry past the top and borrow below zero
    logic [33:0] seq_wide;
    logic [33:0] br_off;
    logic [33:0] br_wide;
    pc_sel_e     sel;

    assign seq_wide = {2'b00, pc} + 34'(WORD_BYTES);
    assign pc_plus4 = seq_wide[31:0];
    assign br_off   = {{16{branch_imm[15]}}, branch_imm, 2'b00};
    assign br_wide  = seq_wide + br_off;

    // Priority decode of the control inputs
    always_comb begin
        if (jump_reg) begin
            sel = SEL_JR;
        end else if (jump) begin
            sel = SEL_J;
        end else if (branch_taken) begin
            sel = SEL_BR;
        end else begin
            sel = SEL_SEQ;
        end
    end

    // Target mux and wrap detection for the selected source
    always_comb begin
        target      = pc_plus4;
        target_wrap = 1'b0;
        unique case (sel)
            SEL_SEQ: begin
                target      = pc_plus4;
                target_wrap = seq_wide[32];
            end
            SEL_BR: begin
                target      = br_wide[31:0];
                target_wrap = |br_wide[33:32];
            end
            SEL_J: begin
                target = {pc_plus4[31:28], jump_index, 2'b00};
            end
            SEL_JR: begin
                target = jr_addr;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: BOOT/RUN/HALT control, fetch-window check and
// saturating retired-instruction counter.
// Optional macro PC_ALIGN_CHECK_EN: when defined, a misaligned target halts
// the sequencer and sets the sticky misaligned flag; otherwise the target's
// low two bits are cleared and misaligned stays 0.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS   = 64,
    parameter logic [31:0] HALT_WORD    = DEFAULT_HALT_WORD,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic [31:0]      instr,
    input  logic             branch_taken,
    input  logic [15:0]      branch_imm,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jump_reg,
    input  logic [31:0]      jr_addr,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             fetch_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count,
    output logic             misaligned
);

    localparam logic [33:0] WIN_LO = {2'b00, RESET_VECTOR};
    localparam logic [33:0] WIN_HI = WIN_LO + 34'(IMEM_WORDS) * 34'(WORD_BYTES);

    seq_state_t       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             mis_q, mis_d;

    logic [31:0]      target_raw;
    logic [31:0]      target_sel;
    logic             target_wrap;
    logic             target_misaligned;
    logic [33:0]      target_ext;
    logic             in_window;

    next_pc_mux u_next_pc_mux (
        .pc           (pc_q),
        .branch_taken (branch_taken),
        .branch_imm   (branch_imm),
        .jump         (jump),
        .jump_index   (jump_index),
        .jump_reg     (jump_reg),
        .jr_addr      (jr_addr),
        .pc_plus4     (pc_plus4),
        .target       (target_raw),
        .target_wrap  (target_wrap)
    );

`ifdef PC_ALIGN_CHECK_EN
    assign target_sel        = target_raw;
    assign target_misaligned = |target_raw[1:0];
`else
    assign target_sel        = target_raw & ~32'h3;
    assign target_misaligned = 1'b0;
`endif

    assign target_ext = {2'b00, target_sel};
    assign in_window  = !target_wrap && (target_ext >= WIN_LO) && (target_ext < WIN_HI);
    assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state logic: stall beats halt detection, which beats target checks
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!stall) begin
                    if (instr == HALT_WORD) begin
                        state_d = HALT;
                    end else if (target_misaligned) begin
                        state_d = HALT;
                        mis_d   = 1'b1;
                    end else if (!in_window) begin
                        // The instruction retires; only the fetch stops
                        state_d = HALT;
                        cnt_d   = cnt_inc;
                    end else begin
                        pc_d  = target_sel;
                        cnt_d = cnt_inc;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = BOOT;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_VECTOR;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = (state_q == RUN);
    assign halted        = (state_q == HALT);
    assign retired_count = cnt_q;
    assign misaligned    = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an architectural model predicts the
// post-edge state of the 64-word instance; a 4-word, 3-bit-counter instance
// covers window exit and counter saturation.
module tb_pc_sequencer;

    localparam logic [31:0] RV      = 32'h0000_0000;
    localparam int unsigned WORDS   = 64;
    localparam logic [31:0] HW      = 32'hFFFF_FFFF;
    localparam longint      CNT_MAX = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instr = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_imm = '0;
    logic        jump = 1'b0;
    logic [25:0] jump_index = '0;
    logic        jump_reg = 1'b0;
    logic [31:0] jr_addr = '0;

    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, halted, misaligned;
    logic [15:0] retired_count;

    logic [31:0] s_pc, s_pc_plus4;
    logic        s_fv, s_halted, s_mis;
    logic [2:0]  s_cnt;

    int total = 0;
    int bad = 0;

    typedef struct {
        longint pc;
        bit     fv;
        bit     halted;
        longint cnt;
        bit     mis;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;

    longint m_pc, m_cnt;
    bit     m_booted, m_halted, m_mis;

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .IMEM_WORDS   (WORDS),
        .HALT_WORD    (HW),
        .CNT_W        (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .instr         (instr),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .halted        (halted),
        .retired_count (retired_count),
        .misaligned    (misaligned)
    );

    pc_sequencer #(
        .RESET_VECTOR (RV),
        .IMEM_WORDS   (4),
        .HALT_WORD    (HW),
        .CNT_W        (3)
    ) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .instr         (instr),
        .branch_taken  (branch_taken),
        .branch_imm    (branch_imm),
        .jump          (jump),
        .jump_index    (jump_index),
        .jump_reg      (jump_reg),
        .jr_addr       (jr_addr),
        .pc            (s_pc),
        .pc_plus4      (s_pc_plus4),
        .fetch_valid   (s_fv),
        .halted        (s_halted),
        .retired_count (s_cnt),
        .misaligned    (s_mis)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: one clock edge of the 64-word sequencer
    task automatic model_step();
        longint p4, t, lo, hi;
        lo = longint'(RV);
        hi = lo + 4 * longint'(WORDS);
        if (m_halted) return;
        if (!m_booted) begin
            m_booted = 1'b1;
            return;
        end
        if (stall) return;
        if (instr == HW) begin
            m_halted = 1'b1;
            return;
        end
        p4 = m_pc + 4;
        if (jump_reg) t = longint'(jr_addr);
        else if (jump) t = (p4 & 64'h0000_0000_F000_0000) + longint'(jump_index) * 4;
        else if (branch_taken) t = p4 + 4 * longint'($signed(branch_imm));
        else t = p4;
`ifdef PC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
            m_halted = 1'b1;
            m_mis    = 1'b1;
            return;
        end
`else
        t = t - (t % 4);
`endif
        if (m_cnt < CNT_MAX) m_cnt++;
        if (t < lo || t >= hi) m_halted = 1'b1;
        else m_pc = t;
    endtask

    // Predict, queue the expectation, then let one edge happen
    task automatic tick();
        exp_t e;
        model_step();
        e.pc     = m_pc;
        e.fv     = m_booted && !m_halted;
        e.halted = m_halted;
        e.cnt    = m_cnt;
        e.mis    = m_mis;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        stall        = 1'b0;
        instr        = 32'h0;
        branch_taken = 1'b0;
        branch_imm   = 16'h0;
        jump         = 1'b0;
        jump_index   = 26'h0;
        jump_reg     = 1'b0;
        jr_addr      = 32'h0;
    endtask

    // Asynchronous reset, checked before any clock edge can intervene
    task automatic apply_reset();
        rst_n = 1'b0;
        sb_q.delete();
        m_pc     = longint'(RV);
        m_cnt    = 0;
        m_booted = 1'b0;
        m_halted = 1'b0;
        m_mis    = 1'b0;
        #1;
        check("rst_pc", pc, RV);
        check("rst_fetch_valid", fetch_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_count", retired_count, 0);
        check("rst_misaligned", misaligned, 0);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: compare the DUT against the queued expectation after each edge
    initial forever begin
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            check("sb_pc", pc, mon_e.pc);
            check("sb_pc_plus4", pc_plus4, (mon_e.pc + 4) & 64'hFFFF_FFFF);
            check("sb_fetch_valid", fetch_valid, mon_e.fv);
            check("sb_halted", halted, mon_e.halted);
            check("sb_count", retired_count, mon_e.cnt);
            check("sb_misaligned", misaligned, mon_e.mis);
        end
    end

    initial begin
        int v;
        int after_halt;

        // Sequential fetch after reset; small instance runs off its window
        idle();
        apply_reset();
        tick();
        check("boot_pc", pc, 32'h0);
        check("boot_fetch_valid", fetch_valid, 1);
        repeat (4) tick();
        check("seq_pc", pc, 32'h10);
        check("seq_count", retired_count, 4);
        check("win_halted", s_halted, 1);
        check("win_pc", s_pc, 32'hC);
        check("win_count", s_cnt, 4);
        check("win_fetch_valid", s_fv, 0);

        // Branch, jump, JR-over-J priority, then stall masking a halt
        apply_reset();
        repeat (3) tick();
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFE;
        tick();
        check("br_back_pc", pc, 32'h4);
        idle();
        jump       = 1'b1;
        jump_index = 26'h10;
        tick();
        check("jump_pc", pc, 32'h40);
        jump_reg = 1'b1;
        jr_addr  = 32'h20;
        tick();
        check("jr_wins_pc", pc, 32'h20);
        idle();
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFB;
        tick();
        check("br_pc", pc, 32'h10);
        idle();
        instr = HW;
        stall = 1'b1;
        repeat (3) begin
            tick();
            check("stall_pc", pc, 32'h10);
            check("stall_halted", halted, 0);
        end
        stall = 1'b0;
        tick();
        check("halt_halted", halted, 1);
        check("halt_pc", pc, 32'h10);
        check("halt_count", retired_count, 6);
        idle();
        tick();
        check("pre_reset_halted", halted, 1);
        apply_reset();

        // Misaligned JR target
        tick();
        jump_reg = 1'b1;
        jr_addr  = 32'h22;
        tick();
`ifdef PC_ALIGN_CHECK_EN
        check("align_halted", halted, 1);
        check("align_misaligned", misaligned, 1);
        check("align_pc", pc, 32'h0);
`else
        check("align_pc", pc, 32'h20);
        check("align_misaligned", misaligned, 0);
`endif
        idle();

        // Self-loop branch saturates the 3-bit counter
        apply_reset();
        tick();
        branch_taken = 1'b1;
        branch_imm   = 16'hFFFF;
        repeat (10) tick();
        check("sat_count", s_cnt, 7);
        check("sat_pc", s_pc, 32'h0);
        check("sat_pc_plus4", s_pc_plus4, 32'h4);
        check("sat_halted", s_halted, 0);
        check("sat_fetch_valid", s_fv, 1);
        check("sat_misaligned", s_mis, 0);
        check("sat_big_count", retired_count, 10);
        idle();

        // Randomized episodes against the model
        for (int ep = 0; ep < 25; ep++) begin
            apply_reset();
            after_halt = 0;
            for (int c = 0; c < 40; c++) begin
                stall        = ($urandom % 5) == 0;
                instr        = (($urandom % 12) == 0) ? HW : $urandom;
                jump_reg     = ($urandom % 8) == 0;
                jump         = ($urandom % 6) == 0;
                branch_taken = ($urandom % 4) == 0;
                v            = int'($urandom_range(0, 16)) - 8;
                branch_imm   = v[15:0];
                jump_index   = 26'($urandom_range(0, 80));
                jr_addr      = $urandom_range(0, 32'h130);
                tick();
                if (m_halted) begin
                    after_halt++;
                    if (after_halt > 2) break;
                end
            end
            idle();
        end

        @(posedge clk);
        #2;
        check("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
